// File: rtl/gpu_sram_pkg.sv
// gpu_sram_pkg: shared constants and types for the GPU frame-buffer SRAM path.
//   - SRAM_ADDR_W / SRAM_DATA_W : geometry of the single GPU SRAM port
//   - arb_state_t               : port arbiter state
//   - COLOR_*                   : 4x4-bit colour words used by the clear engine
package gpu_sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    BLANKED = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2
  } arb_state_t;

  localparam logic [SRAM_DATA_W-1:0] COLOR_BLACK = 16'h0000;
  localparam logic [SRAM_DATA_W-1:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [SRAM_DATA_W-1:0] COLOR_CLEAR = 16'h000F;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority selector.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant (all zero when no request)
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int idx;

  // Walk from the farthest candidate to the nearest so the last hit,
  // i.e. the one closest after ptr, is the one that remains.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx[PW-1:0]]) begin
        gnt = '0;
        gnt[idx[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the GPU SRAM port between NUM_REQ frame-buffer
// requesters during video blanking.
//   I_CLK, I_RST_N (async, active low)
//   I_VIDEO_ON             : scanout owns the SRAM, no grants
//   I_REQ_VALID/WRITE/ADDR/DATA, O_REQ_READY : per-requester valid/ready request
//   O_RD_VALID, O_RD_DATA  : tagged read return, READ_LATENCY+2 after acceptance
//   O_SRAM_ADDR/DATA/READ/WRITE, I_SRAM_DATA : registered SRAM port
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins) instead of round-robin.
module sram_port_arbiter
  import gpu_sram_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_LATENCY = 2
) (
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic                      I_VIDEO_ON,
  input  logic [NUM_REQ-1:0]        I_REQ_VALID,
  input  logic [NUM_REQ-1:0]        I_REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0] I_REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] I_REQ_DATA,
  output logic [NUM_REQ-1:0]        O_REQ_READY,
  output logic [NUM_REQ-1:0]        O_RD_VALID,
  output logic [DATA_W-1:0]         O_RD_DATA,
  input  logic [DATA_W-1:0]         I_SRAM_DATA,
  output logic [DATA_W-1:0]         O_SRAM_DATA,
  output logic [ADDR_W-1:0]         O_SRAM_ADDR,
  output logic                      O_SRAM_READ,
  output logic                      O_SRAM_WRITE
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t                             state;
  logic                                   sram_we;
  logic [IW-1:0]                          sram_id;
  logic [NUM_REQ-1:0]                     req_ok, gnt;
  logic [IW-1:0]                          win;
  logic                                   acc;
  logic [READ_LATENCY-1:0]                tag_vld;
  logic [READ_LATENCY-1:0][IW-1:0]        tag_id;

  // Requests are masked while scanout owns the SRAM or reset is active.
  assign req_ok = I_REQ_VALID & {NUM_REQ{I_RST_N & ~I_VIDEO_ON}};

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // A constant pointer of NUM_REQ-1 makes the search start at index 0.
  localparam logic [IW-1:0] FIX_PTR = IW'(NUM_REQ - 1);
  rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (.req(req_ok), .ptr(FIX_PTR), .gnt(gnt));
`else
  logic [IW-1:0] ptr;
  rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (.req(req_ok), .ptr(ptr), .gnt(gnt));

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)  ptr <= IW'(NUM_REQ - 1);
    else if (acc)  ptr <= win;
  end
`endif

  assign O_REQ_READY = gnt;
  assign acc         = |gnt;

  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt[k]) win = IW'(k);
  end

  // Port FSM; the strobes decode straight from registered state so they drop
  // asynchronously with reset.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= IDLE;
      sram_we     <= 1'b0;
      sram_id     <= '0;
      O_SRAM_ADDR <= '0;
      O_SRAM_DATA <= '0;
    end else if (acc) begin
      state       <= ACCESS;
      sram_we     <= I_REQ_WRITE[win];
      sram_id     <= win;
      O_SRAM_ADDR <= I_REQ_ADDR[win*ADDR_W +: ADDR_W];
      O_SRAM_DATA <= I_REQ_DATA[win*DATA_W +: DATA_W];
    end else begin
      state       <= I_VIDEO_ON ? BLANKED : IDLE;
    end
  end

  assign O_SRAM_READ  = (state == ACCESS) & ~sram_we;
  assign O_SRAM_WRITE = (state == ACCESS) &  sram_we;

  // Read tag pipe starts at the strobe cycle, so the tag leaves the last stage
  // in the cycle the SRAM presents the data.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      tag_vld    <= '0;
      tag_id     <= '0;
      O_RD_VALID <= '0;
      O_RD_DATA  <= '0;
    end else begin
      tag_vld[0] <= O_SRAM_READ;
      tag_id[0]  <= sram_id;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (tag_vld[READ_LATENCY-1]) begin
        O_RD_VALID <= NUM_REQ'(1) << tag_id[READ_LATENCY-1];
        O_RD_DATA  <= I_SRAM_DATA;
      end else begin
        O_RD_VALID <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int N    = 3;
  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int L    = 2;
  localparam int MAXC = 1024;

  logic            I_CLK = 1'b0;
  logic            I_RST_N;
  logic            I_VIDEO_ON;
  logic [N-1:0]    I_REQ_VALID, I_REQ_WRITE;
  logic [N*AW-1:0] I_REQ_ADDR;
  logic [N*DW-1:0] I_REQ_DATA;
  logic [N-1:0]    O_REQ_READY, O_RD_VALID;
  logic [DW-1:0]   O_RD_DATA, I_SRAM_DATA, O_SRAM_DATA;
  logic [AW-1:0]   O_SRAM_ADDR;
  logic            O_SRAM_READ, O_SRAM_WRITE;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(L)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VIDEO_ON(I_VIDEO_ON),
    .I_REQ_VALID(I_REQ_VALID), .I_REQ_WRITE(I_REQ_WRITE),
    .I_REQ_ADDR(I_REQ_ADDR), .I_REQ_DATA(I_REQ_DATA),
    .O_REQ_READY(O_REQ_READY), .O_RD_VALID(O_RD_VALID), .O_RD_DATA(O_RD_DATA),
    .I_SRAM_DATA(I_SRAM_DATA), .O_SRAM_DATA(O_SRAM_DATA), .O_SRAM_ADDR(O_SRAM_ADDR),
    .O_SRAM_READ(O_SRAM_READ), .O_SRAM_WRITE(O_SRAM_WRITE));

  always #5 I_CLK = ~I_CLK;

  int checks = 0, errors = 0;
  int cyc = 0;
  int ptr;
  int last_win;
  // expectations indexed by cycle: strobe kind (0 none, 1 read, 2 write)
  int            exp_s  [MAXC];
  logic [AW-1:0] exp_ad [MAXC];
  logic [DW-1:0] exp_dt [MAXC];
  int            exp_rv [MAXC];
  logic [DW-1:0] exp_rd [MAXC];
  // observations and SRAM stub history
  logic [N-1:0]  obs_rdy[MAXC];
  logic [N-1:0]  obs_rv [MAXC];
  logic [DW-1:0] obs_rd [MAXC];
  logic          obs_srd[MAXC];
  logic          obs_swr[MAXC];
  logic [AW-1:0] hist_ad[MAXC];

  logic [N-1:0]    cur_v, cur_w;
  logic [N*AW-1:0] cur_a;
  logic [N*DW-1:0] cur_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 18'h00A00) return 16'h003F;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    ptr = N - 1;
    last_win = -1;
    for (int i = 0; i < MAXC; i++) begin
      exp_s[i] = 0; exp_rv[i] = -1; obs_srd[i] = 1'b0;
    end
  endtask

  task automatic adv();
    @(posedge I_CLK);
    cyc++;
    #1;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic vid, input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int win;
    logic [AW-1:0] wa;
    I_VIDEO_ON = vid; I_REQ_VALID = v; I_REQ_WRITE = w; I_REQ_ADDR = a; I_REQ_DATA = d;
    if (cyc >= L && obs_srd[cyc-L]) I_SRAM_DATA = mem_val(hist_ad[cyc-L]);
    else I_SRAM_DATA = 16'($urandom);
    #1;
    win = vid ? -1 : pick(v);
    chk("ready", O_REQ_READY, (win < 0) ? 0 : (1 << win));
    chk("sram_read", O_SRAM_READ, exp_s[cyc] == 1);
    chk("sram_write", O_SRAM_WRITE, exp_s[cyc] == 2);
    if (exp_s[cyc] != 0) chk("sram_addr", O_SRAM_ADDR, exp_ad[cyc]);
    if (exp_s[cyc] == 2) chk("sram_data", O_SRAM_DATA, exp_dt[cyc]);
    chk("rd_valid", O_RD_VALID, (exp_rv[cyc] < 0) ? 0 : (1 << exp_rv[cyc]));
    if (exp_rv[cyc] >= 0) chk("rd_data", O_RD_DATA, exp_rd[cyc]);
    obs_rdy[cyc] = O_REQ_READY; obs_rv[cyc] = O_RD_VALID; obs_rd[cyc] = O_RD_DATA;
    obs_srd[cyc] = O_SRAM_READ; obs_swr[cyc] = O_SRAM_WRITE; hist_ad[cyc] = O_SRAM_ADDR;
    last_win = win;
    if (win >= 0) begin
      ptr = win;
      wa = a[win*AW +: AW];
      exp_s[cyc+1]  = w[win] ? 2 : 1;
      exp_ad[cyc+1] = wa;
      exp_dt[cyc+1] = d[win*DW +: DW];
      if (!w[win]) begin
        exp_rv[cyc+L+2] = win;
        exp_rd[cyc+L+2] = mem_val(wa);
      end
    end
    adv();
  endtask

  typedef struct {
    logic         vid;
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    logic         exp_wr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int acc, n0, n2, nz;
    logic vid;
    // {vid, valid, expected ready, expected write strobe}
`ifdef SRAM_ARB_FIXED_PRIO_EN
    tbl[0] = '{1'b0, 3'b111, 3'b001, 1'b0};
    tbl[1] = '{1'b0, 3'b111, 3'b001, 1'b1};
    tbl[2] = '{1'b0, 3'b111, 3'b001, 1'b1};
    tbl[3] = '{1'b0, 3'b111, 3'b001, 1'b1};
    tbl[4] = '{1'b0, 3'b111, 3'b001, 1'b1};
    tbl[5] = '{1'b0, 3'b111, 3'b001, 1'b1};
`else
    tbl[0] = '{1'b0, 3'b111, 3'b001, 1'b0};
    tbl[1] = '{1'b0, 3'b111, 3'b010, 1'b1};
    tbl[2] = '{1'b0, 3'b111, 3'b100, 1'b1};
    tbl[3] = '{1'b0, 3'b111, 3'b001, 1'b1};
    tbl[4] = '{1'b0, 3'b111, 3'b010, 1'b1};
    tbl[5] = '{1'b0, 3'b111, 3'b100, 1'b1};
`endif
    tbl[6] = '{1'b1, 3'b111, 3'b000, 1'b1};
    tbl[7] = '{1'b1, 3'b111, 3'b000, 1'b0};
    tbl[8] = '{1'b0, 3'b111, 3'b001, 1'b0};

    // reset state
    I_RST_N = 1'b0; I_VIDEO_ON = 1'b0; I_REQ_VALID = '1; I_REQ_WRITE = '1;
    I_REQ_ADDR = '0; I_REQ_DATA = '0; I_SRAM_DATA = '0;
    model_reset();
    @(posedge I_CLK); @(posedge I_CLK); #1;
    chk("rst_ready", O_REQ_READY, 0);
    chk("rst_strobes", {O_SRAM_READ, O_SRAM_WRITE}, 0);
    chk("rst_addr", O_SRAM_ADDR, 0);
    chk("rst_data", O_SRAM_DATA, 0);
    chk("rst_rd", {O_RD_VALID, O_RD_DATA}, 0);
    I_RST_N = 1'b1;
    cyc = 0;

    // table: all-write round robin, blanking, resume from stored pointer
    for (int i = 0; i < 9; i++) begin
      acc = cyc;
      cycle(tbl[i].vid, tbl[i].valid, 3'b111,
            {18'h00300, 18'h00200, 18'h00100}, {16'hC0C2, 16'hC0C1, 16'hC0C0});
      chk("tbl_ready", obs_rdy[acc], tbl[i].exp_ready);
      chk("tbl_wr", obs_swr[acc], tbl[i].exp_wr);
    end
    cycle(0, 3'b000, 3'b000, '0, '0);

    // tagged read from requester 1
    acc = cyc;
    cycle(0, 3'b010, 3'b000, {18'h0, 18'h00A00, 18'h0}, '0);
    for (int i = 0; i < 5; i++) cycle(0, 3'b000, 3'b000, '0, '0);
    chk("rd_lat_early", obs_rv[acc+3], 0);
    chk("rd_lat_valid", obs_rv[acc+4], 3'b010);
    chk("rd_lat_data", obs_rd[acc+4], 16'h003F);

    // video rises the cycle after a read is accepted
    acc = cyc;
    cycle(0, 3'b010, 3'b000, {18'h0, 18'h00B00, 18'h0}, '0);
    for (int i = 0; i < 6; i++) cycle(1, 3'b111, 3'b000, {18'h1, 18'h2, 18'h3}, '0);
    chk("vid_strobe", obs_srd[acc+1], 1'b1);
    chk("vid_rd_valid", obs_rv[acc+4], 3'b010);
    chk("vid_rd_data", obs_rd[acc+4], mem_val(18'h00B00));
    nz = 0;
    for (int i = 1; i <= 6; i++) if (obs_rdy[acc+i] != 0) nz++;
    chk("vid_no_grant", nz, 0);

    // reset with two reads in flight
    cycle(0, 3'b001, 3'b000, {18'h0, 18'h0, 18'h00C01}, '0);
    cycle(0, 3'b100, 3'b000, {18'h00C02, 18'h0, 18'h0}, '0);
    chk("pre_rst_strobe", O_SRAM_READ, 1'b1);
    #2 I_RST_N = 1'b0;
    #1;
    chk("rst_async_strobes", {O_SRAM_READ, O_SRAM_WRITE}, 0);
    chk("rst_async_ready", O_REQ_READY, 0);
    model_reset();
    adv();
    I_RST_N = 1'b1;
    acc = cyc;
    for (int i = 0; i < 6; i++) cycle(0, 3'b000, 3'b000, '0, '0);
    nz = 0;
    for (int i = 0; i < 6; i++) if (obs_rv[acc+i] != 0) nz++;
    chk("rst_no_rd_valid", nz, 0);
    acc = cyc;
    cycle(0, 3'b111, 3'b111, '0, '0);
    chk("rst_first_grant", obs_rdy[acc], 3'b001);

    // requesters 0 and 2 contend for 4 cycles
    n0 = 0; n2 = 0;
    for (int i = 0; i < 4; i++) begin
      acc = cyc;
      cycle(0, 3'b101, 3'b101, {18'h00222, 18'h0, 18'h00111}, '0);
      if (obs_rdy[acc][0]) n0++;
      if (obs_rdy[acc][2]) n2++;
    end
`ifdef SRAM_ARB_FIXED_PRIO_EN
    chk("prio_req0", n0, 4);
    chk("prio_req2", n2, 0);
`else
    chk("rr_req0", n0, 2);
    chk("rr_req2", n2, 2);
`endif

    // randomized traffic; held requests keep their payload until granted
    cur_v = '0; cur_w = '0; cur_a = '0; cur_d = '0;
    last_win = -1;
    for (int t = 0; t < 400; t++) begin
      vid = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < N; k++) begin
        if (!cur_v[k] || k == last_win) begin
          cur_v[k] = ($urandom_range(0, 2) != 0);
          cur_w[k] = $urandom_range(0, 1);
          cur_a[k*AW +: AW] = AW'($urandom);
          cur_d[k*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          cur_v[k] = 1'b0;
        end
      end
      cycle(vid, cur_v, cur_w, cur_a, cur_d);
    end
    for (int i = 0; i < 6; i++) cycle(0, 3'b000, 3'b000, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single GPU-SRAM port (18-bit address, 16-bit data) between NUM_REQ frame-buffer requesters, e.g. the line rasterizer, the screen-clear engine and the pixel readback unit.
- Grants access only while I_VIDEO_ON is low, because scanout owns the SRAM while video is on.
- Uses round-robin arbitration, a valid/ready request handshake and a fixed-latency read-return path tagged to the originating requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width (4x4-bit colour).
- READ_LATENCY, 2, cycles from the O_SRAM_READ strobe to valid I_SRAM_DATA (1..4).

Ports:
- I_CLK  in  1  system clock, all logic on the rising edge.
- I_RST_N  in  1  asynchronous active-low reset.
- I_VIDEO_ON  in  1  high while scanout owns the SRAM; no grants then.
- I_REQ_VALID  in  NUM_REQ  per-requester request valid.
- I_REQ_WRITE  in  NUM_REQ  per-requester access type: 1 = write, 0 = read.
- I_REQ_ADDR  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies [k*ADDR_W +: ADDR_W].
- I_REQ_DATA  in  NUM_REQ*DATA_W  packed write data.
- O_REQ_READY  out  NUM_REQ  one-hot grant, combinational; a transfer occurs when valid and ready are both high.
- O_RD_VALID  out  NUM_REQ  one-hot pulse marking returned read data.
- O_RD_DATA  out  DATA_W  returned read data, shared by all requesters.
- I_SRAM_DATA  in  DATA_W  SRAM read data.
- O_SRAM_DATA  out  DATA_W  SRAM write data, registered.
- O_SRAM_ADDR  out  ADDR_W  SRAM address, registered.
- O_SRAM_READ  out  1  read strobe, registered.
- O_SRAM_WRITE  out  1  write strobe, registered.

Behaviour:
- Reset values: O_SRAM_ADDR = 0, O_SRAM_DATA = 0, O_SRAM_READ = 0, O_SRAM_WRITE = 0, O_RD_VALID = 0, O_RD_DATA = 0. The read pipeline is cleared. The round-robin pointer is NUM_REQ-1, so requester 0 wins first.
- O_REQ_READY is 0 whenever reset is asserted or I_VIDEO_ON = 1.
- States:
  - BLANKED: I_VIDEO_ON = 1. Strobes are 0.
  - IDLE: video off, no valid request. Strobes are 0.
  - ACCESS: a request was accepted on the previous edge; exactly one strobe is 1.
- Transitions are re-evaluated every cycle. BLANKED has priority: if I_VIDEO_ON rises while in ACCESS, the strobes drop on the next edge.
- Arbitration: the winner is the first asserted I_REQ_VALID searching upward (with wrap) from pointer+1. O_REQ_READY[winner] = 1 in the same cycle. On acceptance the pointer becomes the winner's index.
- At most one acceptance per cycle. Back-to-back acceptances are allowed, giving one SRAM access per cycle.
- Acceptance latency: 1 cycle. On the next edge the winner's address, data and write bit are registered into O_SRAM_*. A write sets O_SRAM_WRITE = 1, O_SRAM_READ = 0; a read does the reverse.
- Read return: a READ_LATENCY-deep shift register carries {valid, requester id}. When the tag emerges, I_SRAM_DATA is registered into O_RD_DATA and O_RD_VALID[id] pulses for one cycle. Total read latency from acceptance to O_RD_VALID is READ_LATENCY+2 cycles.
- In-flight reads complete even if I_VIDEO_ON rises.
- Requesters must hold addr/data/write stable while valid is high and ready is low. Dropping valid without acceptance is legal and causes no access.
- A lone requester holding valid continuously is granted every cycle.
- Reset mid-operation clears everything immediately: strobes drop asynchronously and the pending read tags are discarded, so no O_RD_VALID follows.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is removed.
- Undefined: round-robin as described above.

Decomposition:
- Package gpu_sram_pkg holds:
  - the address and data width constants (18 and 16);
  - the arbiter state enum {BLANKED, IDLE, ACCESS};
  - the colour constants used by the clear engine.
- One natural sub-module, rr_pick: a combinational rotating priority selector (request vector and pointer in, one-hot grant out). It is reused by future arbiters.

Test Plan:
- Reset, then I_VIDEO_ON = 0 with I_REQ_VALID = 3'b111, all writes, for 6 cycles:
  - grant order is 0,1,2,0,1,2;
  - O_SRAM_WRITE = 1 every cycle from cycle 2;
  - O_SRAM_ADDR matches the winner's address one cycle after each grant.
- Requester 1 issues a read of address 18'h00A00, with I_SRAM_DATA = 16'h003F supplied 2 cycles after O_SRAM_READ:
  - O_RD_VALID = 3'b010 and O_RD_DATA = 16'h003F exactly 4 cycles after acceptance.
- I_VIDEO_ON = 1 with all requests valid:
  - O_REQ_READY stays 0 and the strobes stay 0;
  - when I_VIDEO_ON falls, the first grant follows the stored pointer.
- Raise I_VIDEO_ON on the cycle after a read is accepted:
  - the strobe still issues for that access;
  - O_RD_VALID still pulses READ_LATENCY+2 cycles after acceptance;
  - no new grants are issued.
- Assert I_RST_N low while two reads are in flight:
  - the strobes drop asynchronously;
  - no O_RD_VALID pulses after release;
  - the first grant after release goes to requester 0.
- With SRAM_ARB_FIXED_PRIO_EN defined and requesters 0 and 2 both valid for 4 cycles:
  - requester 0 is granted all 4 cycles and requester 2 gets none.
